zx_sd_spi: RTL and testbench
============================

Name: zx_sd_spi

Overview:
- SD-card SPI master behind the ULA's Z-Controller-compatible I/O ports. Port 0x77 is the control port and port 0x57 is the data port.
- The ULA I/O decoder supplies one-cycle strobes. This block drives sd_cs_n/sd_sck/sd_mosi and returns the received byte to the CPU data bus mux.
- Runs on clk28. Decouples slow Z80 I/O cycles from bit-level SPI timing with a one-entry command buffer.

Parameters:
- FAST_DIV, 1: SCK half-period in clk28 cycles, fast mode (14 MHz SCK).
- SLOW_DIV, 35: SCK half-period in clk28 cycles, init mode (400 kHz SCK).

Ports:
- clk28  in  1  28 MHz system clock
- rst_n  in  1  asynchronous active-low reset
- ctrl_wr  in  1  one-cycle strobe, OUT to 0x77; loads control from din
- data_wr  in  1  one-cycle strobe, OUT to 0x57; sends din
- data_rd  in  1  one-cycle strobe, IN from 0x57; sends 0xFF
- din  in  8  CPU write data
- dout  out  8  last received byte
- busy  out  1  transfer in progress or pending
- overrun  out  1  sticky: a strobe was dropped
- sd_cd  in  1  card detect, 0 = card present (asynchronous)
- sd_miso  in  1  SPI data in
- sd_cs_n  out  1  SPI chip select
- sd_sck  out  1  SPI clock, mode 0
- sd_mosi  out  1  SPI data out

Behaviour:
- Reset values:
  - sd_cs_n=1, sd_sck=0, sd_mosi=1, dout=0xFF, busy=0, overrun=0.
  - Control register: cs=1, slow=1. Pending buffer empty.
  - Asserting rst_n low mid-transfer aborts the transfer immediately with these values.
- Control write (ctrl_wr):
  - cs := din[1], slow := din[2]. Takes effect the next cycle, even during a transfer.
  - Clears overrun.
- Chip select: sd_cs_n = cs | cd_sync. cd_sync is sd_cd through a 2-flop synchroniser; with no card present, CS stays deasserted.
- Starting a transfer:
  - A data_wr takes tx=din. A data_rd takes tx=0xFF.
  - dout presents the previous received byte during the data_rd cycle, i.e. registered rx before update.
- FSM states: IDLE, LOW (sck=0), HIGH (sck=1). A half-period counter counts DIV cycles; a bit counter runs 7..0.
  - DIV is latched from slow at transfer start.
- Transfer timing, strobe in cycle N while IDLE:
  - Cycle N+1: busy=1, state LOW, sd_mosi=tx[7].
  - After DIV cycles in LOW: sck rises, state HIGH, sd_miso is sampled into the shift register on that same clk28 edge.
  - After DIV cycles in HIGH: sck falls, and mosi takes the next bit.
  - After the 8th HIGH phase: sck=0, rx is loaded into dout, sd_mosi=1.
  - Total: busy spans 16*DIV cycles; dout is updated and busy=0 at N+16*DIV+1 if nothing is pending.
- Pending buffer, one entry holding tx byte and kind:
  - A strobe while busy with the buffer empty is stored.
  - At completion, the stored transfer starts on the next cycle; busy stays 1 throughout.
  - A strobe while the buffer is full is dropped and sets overrun.
  - A data_rd queued in the buffer still presents the current dout at strobe time.
- Simultaneous events:
  - ctrl_wr together with a data strobe: the control update applies first, so the new slow value is used if the transfer starts that cycle.
  - data_wr and data_rd together: data_wr wins and the read is ignored, with no overrun.
- Card removal (cd_sync→1) mid-transfer: sd_cs_n rises immediately, and the transfer completes normally with meaningless data.
- sd_miso is sampled directly. The SD card drives it from SCK, which is synchronous to clk28.

Test Plan:
- Reset then ctrl_wr din=0x00 (cs=0, fast), sd_cd=0, data_wr din=0xA5 with a MISO model returning 0x3C:
  - sd_mosi bits 1,0,1,0,0,1,0,1 on eight sck rises.
  - busy high for exactly 16 cycles, then dout=0x3C.
- ctrl_wr din=0x04 (slow), data_wr 0x00:
  - sck period 70 clk28 cycles, busy for 560 cycles.
- Back-to-back data_wr 0x11 then 0x22 two cycles apart:
  - Both bytes appear on MOSI contiguously, busy never drops between them, overrun=0.
- Three data_wr strobes within one transfer:
  - The third is dropped and overrun=1; a following ctrl_wr clears overrun.
- data_rd with dout=0x3C and MISO=0x5A:
  - dout reads 0x3C in the strobe cycle; MOSI sends 0xFF; dout=0x5A afterwards.
- rst_n pulsed low at mid-byte (bit 4):
  - Outputs immediately go to cs_n=1, sck=0, mosi=1, dout=0xFF, busy=0.
- sd_cd=1 with cs=0:
  - sd_cs_n=1 after two clk28 cycles.

Source files
------------

// File: rtl/zx_sd_spi.sv
// SD-card SPI master for the Z-Controller ports (0x77 control, 0x57 data).
// One transfer in flight plus a one-entry pending buffer; mode-0 SCK from clk28.
module zx_sd_spi #(
  parameter int FAST_DIV = 1,
  parameter int SLOW_DIV = 35
) (
  input  logic       i_clk28,
  input  logic       i_rst_n,
  input  logic       i_ctrl_wr,
  input  logic       i_data_wr,
  input  logic       i_data_rd,
  input  logic [7:0] i_din,
  output logic [7:0] o_dout,
  output logic       o_busy,
  output logic       o_overrun,
  input  logic       i_sd_cd,
  input  logic       i_sd_miso,
  output logic       o_sd_cs_n,
  output logic       o_sd_sck,
  output logic       o_sd_mosi
);

  // state  | meaning
  // IDLE   | no transfer, sck=0, mosi=1
  // LOW    | sck=0, mosi holds current bit
  // HIGH   | sck=1, miso sampled on entry
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOW  = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;

  localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int CW     = $clog2(MAXDIV) + 1;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_div;
  logic [2:0]    r_bit;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic [7:0]    r_dout;
  logic          r_pend_v;
  logic [7:0]    r_pend_tx;
  logic          r_overrun;
  logic          r_cs;
  logic          r_slow;
  logic          r_cd_s1;
  logic          r_cd_sync;

  logic          w_strobe;
  logic [7:0]    w_tx;
  logic          w_slow_eff;
  logic [CW-1:0] w_div_m1;
  logic          w_active;
  logic          w_tick;
  logic          w_done;
  logic          w_start;
  logic [7:0]    w_start_tx;

  assign w_strobe   = i_data_wr | i_data_rd;
  assign w_tx       = i_data_wr ? i_din : 8'hFF;
  // a control write in the same cycle as a start already selects the new speed
  assign w_slow_eff = i_ctrl_wr ? i_din[2] : r_slow;
  assign w_div_m1   = w_slow_eff ? CW'(SLOW_DIV - 1) : CW'(FAST_DIV - 1);
  assign w_active   = (r_state != S_IDLE);
  assign w_tick     = (r_cnt == '0);
  assign w_done     = (r_state == S_HIGH) && w_tick && (r_bit == 3'd0);
  assign w_start    = ((r_state == S_IDLE) && w_strobe) ||
                      (w_done && (r_pend_v || w_strobe));
  assign w_start_tx = (w_done && r_pend_v) ? r_pend_tx : w_tx;

  always_ff @(posedge i_clk28 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_div     <= '0;
      r_bit     <= 3'd0;
      r_tx      <= 8'hFF;
      r_rx      <= 8'hFF;
      r_dout    <= 8'hFF;
      r_pend_v  <= 1'b0;
      r_pend_tx <= 8'hFF;
      r_overrun <= 1'b0;
      r_cs      <= 1'b1;
      r_slow    <= 1'b1;
      r_cd_s1   <= 1'b1;
      r_cd_sync <= 1'b1;
    end else begin
      r_cd_s1   <= i_sd_cd;
      r_cd_sync <= r_cd_s1;

      if (i_ctrl_wr) begin
        r_cs      <= i_din[1];
        r_slow    <= i_din[2];
        r_overrun <= 1'b0;
      end

      // buffer slot frees at completion, so a strobe landing then is kept
      if (w_strobe && w_active) begin
        if (w_done) begin
          if (r_pend_v) r_pend_tx <= w_tx;
        end else if (!r_pend_v) begin
          r_pend_v  <= 1'b1;
          r_pend_tx <= w_tx;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_done && r_pend_v) begin
        r_pend_v <= 1'b0;
      end

      if (w_done) r_dout <= r_rx;

      if (w_start) begin
        r_state <= S_LOW;
        r_tx    <= w_start_tx;
        r_cnt   <= w_div_m1;
        r_div   <= w_div_m1;
        r_bit   <= 3'd7;
      end else begin
        case (r_state)
          S_LOW: begin
            if (w_tick) begin
              r_state <= S_HIGH;
              r_rx    <= {r_rx[6:0], i_sd_miso};
              r_cnt   <= r_div;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          S_HIGH: begin
            if (w_tick) begin
              if (r_bit == 3'd0) begin
                r_state <= S_IDLE;
              end else begin
                r_state <= S_LOW;
                r_bit   <= r_bit - 3'd1;
                r_tx    <= {r_tx[6:0], 1'b1};
                r_cnt   <= r_div;
              end
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_dout    = r_dout;
  assign o_busy    = w_active | r_pend_v;
  assign o_overrun = r_overrun;
  assign o_sd_cs_n = r_cs | r_cd_sync;
  assign o_sd_sck  = (r_state == S_HIGH);
  assign o_sd_mosi = w_active ? r_tx[7] : 1'b1;

endmodule

// File: tb/tb_zx_sd_spi.sv
// Bench for zx_sd_spi: vector table, randomized transfers against a byte-level
// model, and hand-written sequences for buffering, overrun, reset and card detect.
module tb_zx_sd_spi;
  localparam int FAST = 1;
  localparam int SLOW = 35;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ctrl_wr = 1'b0;
  logic       data_wr = 1'b0;
  logic       data_rd = 1'b0;
  logic [7:0] din = 8'h00;
  logic       sd_cd = 1'b0;
  logic       sd_miso;
  logic [7:0] dout;
  logic       busy, overrun, cs_n, sck, mosi;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zx_sd_spi #(.FAST_DIV(FAST), .SLOW_DIV(SLOW)) dut (
    .i_clk28(clk), .i_rst_n(rst_n), .i_ctrl_wr(ctrl_wr), .i_data_wr(data_wr),
    .i_data_rd(data_rd), .i_din(din), .o_dout(dout), .o_busy(busy),
    .o_overrun(overrun), .i_sd_cd(sd_cd), .i_sd_miso(sd_miso),
    .o_sd_cs_n(cs_n), .o_sd_sck(sck), .o_sd_mosi(mosi)
  );

  // card model: MISO bytes MSB first, advancing on each observed SCK rise
  int          cyc = 0;
  int          rise_cnt = 0;
  int          miso_base = 0;
  logic        prev_sck = 1'b0;
  logic [7:0]  miso_arr [0:3];
  logic        mosi_hist [0:4095];
  int          rise_cyc [0:4095];
  logic [31:0] miso_idx;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (sck && !prev_sck) begin
      mosi_hist[rise_cnt & 4095] = mosi;
      rise_cyc[rise_cnt & 4095]  = cyc;
      rise_cnt++;
    end
    prev_sck = sck;
  end

  always_comb begin
    miso_idx = rise_cnt - miso_base;
    sd_miso  = miso_arr[miso_idx[4:3]][3'd7 - miso_idx[2:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hist_byte(input int b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r = {r[6:0], mosi_hist[(b + i) & 4095]};
    return r;
  endfunction

  task automatic ctrl(input logic [7:0] v);
    @(negedge clk);
    din = v; ctrl_wr = 1'b1;
    @(negedge clk);
    ctrl_wr = 1'b0;
  endtask

  // kind: 0 = data_wr, 1 = data_rd, 2 = both together
  task automatic xfer(input int kind, input logic [7:0] d, input logic [7:0] m,
                      input bit ctrl_same, output logic [7:0] dstb,
                      output logic [7:0] mosi_b, output logic [7:0] dafter,
                      output int busy_cyc, output int period);
    int base;
    @(negedge clk);
    base = rise_cnt;
    miso_base = rise_cnt;
    miso_arr[0] = m;
    din = d;
    data_wr = (kind != 1);
    data_rd = (kind != 0);
    ctrl_wr = ctrl_same;
    dstb = dout;
    @(negedge clk);
    data_wr = 1'b0; data_rd = 1'b0; ctrl_wr = 1'b0;
    busy_cyc = 0;
    while (busy && busy_cyc < 2000) begin
      busy_cyc++;
      @(negedge clk);
    end
    dafter = dout;
    mosi_b = hist_byte(base);
    period = rise_cyc[(base + 1) & 4095] - rise_cyc[base & 4095];
  endtask

  typedef struct {
    logic [7:0] ctrl;
    bit         ctrl_same;
    int         kind;
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] e_dstb;
    logic [7:0] e_mosi;
    logic [7:0] e_dout;
    int         e_busy;
    int         e_per;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0] dstb, mb, da;
    int bc, per, n, base, kind, slow;
    logic [7:0] d, m, model_dout;
    bit same;

    vecs[0] = '{8'h00, 1'b0, 0, 8'hA5, 8'h3C, 8'hFF, 8'hA5, 8'h3C, 16*FAST, 2*FAST};
    vecs[1] = '{8'h00, 1'b0, 1, 8'h00, 8'h5A, 8'h3C, 8'hFF, 8'h5A, 16*FAST, 2*FAST};
    vecs[2] = '{8'h04, 1'b0, 0, 8'h00, 8'hC3, 8'h5A, 8'h00, 8'hC3, 16*SLOW, 2*SLOW};
    vecs[3] = '{8'h00, 1'b1, 0, 8'h00, 8'h81, 8'hC3, 8'h00, 8'h81, 16*FAST, 2*FAST};
    vecs[4] = '{8'h00, 1'b0, 2, 8'h96, 8'h7E, 8'h81, 8'h96, 8'h7E, 16*FAST, 2*FAST};
    vecs[5] = '{8'h00, 1'b1, 0, 8'h04, 8'h24, 8'h7E, 8'h04, 8'h24, 16*SLOW, 2*SLOW};

    for (int i = 0; i < 4; i++) miso_arr[i] = 8'hFF;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sck", sck, 1'b0);
    chk("rst_mosi", mosi, 1'b1);
    chk("rst_dout", dout, 8'hFF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_cs_n_ctrl", cs_n, 1'b1);

    ctrl(8'h00);
    chk("cs_asserted", cs_n, 1'b0);

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].ctrl_same) ctrl(vecs[i].ctrl);
      xfer(vecs[i].kind, vecs[i].d, vecs[i].m, vecs[i].ctrl_same, dstb, mb, da, bc, per);
      chk($sformatf("vec%0d_dout_strobe", i), dstb, vecs[i].e_dstb);
      chk($sformatf("vec%0d_mosi", i), mb, vecs[i].e_mosi);
      chk($sformatf("vec%0d_dout", i), da, vecs[i].e_dout);
      chk($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].e_busy);
      chk($sformatf("vec%0d_sck_period", i), per, vecs[i].e_per);
      chk($sformatf("vec%0d_overrun", i), overrun, 1'b0);
    end

    // randomized single transfers against a byte-level model
    model_dout = 8'h24;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 2);
      d    = 8'($urandom);
      m    = 8'($urandom);
      same = ($urandom_range(0, 3) == 0);
      if (same) begin
        slow = d[2];
      end else begin
        slow = ($urandom_range(0, 9) == 0);
        ctrl(slow ? 8'h04 : 8'h00);
      end
      xfer(kind, d, m, same, dstb, mb, da, bc, per);
      chk($sformatf("rnd%0d_dout_strobe", i), dstb, model_dout);
      chk($sformatf("rnd%0d_mosi", i), mb, (kind == 1) ? 8'hFF : d);
      chk($sformatf("rnd%0d_dout", i), da, m);
      chk($sformatf("rnd%0d_busy_cycles", i), bc, 16 * (slow ? SLOW : FAST));
      model_dout = m;
    end

    // two writes two cycles apart: contiguous on the wire, busy never drops
    ctrl(8'h00);
    @(negedge clk);
    base = rise_cnt; miso_base = rise_cnt;
    miso_arr[0] = 8'h3A; miso_arr[1] = 8'hC5;
    din = 8'h11; data_wr = 1'b1;
    @(negedge clk);
    data_wr = 1'b0; n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 2) begin din = 8'h22; data_wr = 1'b1; end
      else data_wr = 1'b0;
      @(negedge clk);
    end
    data_wr = 1'b0;
    chk("b2b_busy_cycles", n, 32 * FAST);
    chk("b2b_mosi0", hist_byte(base), 8'h11);
    chk("b2b_mosi1", hist_byte(base + 8), 8'h22);
    chk("b2b_gap", rise_cyc[(base + 8) & 4095] - rise_cyc[(base + 7) & 4095], 2 * FAST);
    chk("b2b_overrun", overrun, 1'b0);
    chk("b2b_dout", dout, 8'hC5);

    // third strobe inside one transfer is dropped
    @(negedge clk);
    base = rise_cnt; miso_base = rise_cnt;
    din = 8'h11; data_wr = 1'b1;
    @(negedge clk);
    data_wr = 1'b0; n = 0;
    while (busy && n < 200) begin
      n++;
      if (n == 2) begin din = 8'h22; data_wr = 1'b1; end
      else if (n == 4) begin din = 8'h33; data_wr = 1'b1; end
      else data_wr = 1'b0;
      @(negedge clk);
    end
    data_wr = 1'b0;
    chk("ovr_busy_cycles", n, 32 * FAST);
    chk("ovr_mosi1", hist_byte(base + 8), 8'h22);
    chk("ovr_flag", overrun, 1'b1);
    ctrl(8'h00);
    chk("ovr_cleared", overrun, 1'b0);

    // reset mid-byte while SCK is high on bit 4
    ctrl(8'h04);
    @(negedge clk);
    base = rise_cnt; miso_base = rise_cnt;
    din = 8'h00; data_wr = 1'b1;
    @(negedge clk);
    data_wr = 1'b0; n = 0;
    while ((rise_cnt - base) < 4 && n < 1000) begin n++; @(negedge clk); end
    chk("midrst_pre_sck", sck, 1'b1);
    chk("midrst_pre_cs_n", cs_n, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", cs_n, 1'b1);
    chk("midrst_sck", sck, 1'b0);
    chk("midrst_mosi", mosi, 1'b1);
    chk("midrst_dout", dout, 8'hFF);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // card detect passes through a two-flop synchroniser
    ctrl(8'h00);
    repeat (3) @(negedge clk);
    chk("cd_present", cs_n, 1'b0);
    sd_cd = 1'b1;
    @(negedge clk);
    chk("cd_one_cycle", cs_n, 1'b0);
    @(negedge clk);
    chk("cd_two_cycles", cs_n, 1'b1);
    sd_cd = 1'b0;
    repeat (2) @(negedge clk);
    chk("cd_reinserted", cs_n, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
